// File: rtl/param_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// param_rd_ctrl_if
//
// Purpose: carries one beat of the weight/bias parameter stream between the
// read controller and the consumer that takes the ROM outputs.
//
// Signals:
//   param_rd_addr  weight ROM address shared by the five row ROMs
//   conv_cnt       kernel index, doubles as the bias ROM address
//   w_valid        ROM outputs hold a valid beat this cycle
//   w_ready        consumer accepts the beat when w_valid && w_ready
//   w_col, w_ch    kernel column and input channel of the current beat
//   w_first_k      first beat of a kernel (bias output valid with it)
//   w_last_k       last beat of a kernel
//   w_last         last beat of the layer
//
// Modports: master = controller side, slave = consumer side.
// ---------------------------------------------------------------------------
interface param_rd_ctrl_if;
    logic [7:0] param_rd_addr;
    logic [4:0] conv_cnt;
    logic       w_valid;
    logic       w_ready;
    logic [2:0] w_col;
    logic [4:0] w_ch;
    logic       w_first_k;
    logic       w_last_k;
    logic       w_last;

    modport master (
        output param_rd_addr, conv_cnt, w_valid, w_col, w_ch,
               w_first_k, w_last_k, w_last,
        input  w_ready
    );

    modport slave (
        input  param_rd_addr, conv_cnt, w_valid, w_col, w_ch,
               w_first_k, w_last_k, w_last,
        output w_ready
    );
endinterface

// File: rtl/param_rd_ctrl.sv
// ---------------------------------------------------------------------------
// param_rd_ctrl
//
// Purpose: walks the weight and bias ROMs of one convolution layer and
// presents every (kernel, channel, column) beat to a consumer through a
// valid/ready handshake. The ROMs have one cycle of read latency, so every
// new address is held for one RD cycle before the beat is shown as valid.
//
// Parameters:
//   KER_NUM  kernels per layer (1..32)
//   CH_NUM   input channels per kernel (KER_NUM*CH_NUM*5 <= 256)
//
// Ports:
//   sclk   in   clock, rising edge
//   s_rst  in   synchronous active-high reset
//   start  in   single-cycle request to stream one layer
//   busy   out  high while a layer is being streamed
//   done   out  one-cycle pulse after the last beat is accepted
//   wif    master modport of param_rd_ctrl_if (beat stream)
// ---------------------------------------------------------------------------
module param_rd_ctrl #(
    parameter int KER_NUM = 16,
    parameter int CH_NUM  = 3
) (
    input  logic            sclk,
    input  logic            s_rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    param_rd_ctrl_if.master wif
);

    localparam logic [4:0] CH_LAST  = 5'(CH_NUM - 1);
    localparam logic [4:0] KER_LAST = 5'(KER_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        VLD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] addr_q;
    logic [4:0] conv_q;
    logic [2:0] colCnt_q;
    logic [4:0] chCnt_q;
    logic       valid_q;
    logic [2:0] tagCol_q;
    logic [4:0] tagCh_q;
    logic       firstK_q;
    logic       lastK_q;
    logic       last_q;

    logic       atLastK;

    // The beat about to be presented closes a kernel when the column and
    // channel counters both sit at their final values.
    always_comb begin
        atLastK = (colCnt_q == 3'd4) && (chCnt_q == CH_LAST);
    end

    // Single state machine. Position counters (col/ch/conv) and the address
    // advance only on an accepted beat. The beat tags are loaded from the
    // counters when entering VLD and cleared when leaving it, so they read
    // zero whenever w_valid is low. The address keeps counting linearly,
    // which matches (conv*CH_NUM + ch)*5 + col because col is the fastest
    // index and all indices advance in lock-step with it.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= 8'd0;
            conv_q   <= 5'd0;
            colCnt_q <= 3'd0;
            chCnt_q  <= 5'd0;
            valid_q  <= 1'b0;
            tagCol_q <= 3'd0;
            tagCh_q  <= 5'd0;
            firstK_q <= 1'b0;
            lastK_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= 8'd0;
                        conv_q   <= 5'd0;
                        colCnt_q <= 3'd0;
                        chCnt_q  <= 5'd0;
                        busy_q   <= 1'b1;
                        state_q  <= RD;
                    end
                end
                RD: begin
                    valid_q  <= 1'b1;
                    tagCol_q <= colCnt_q;
                    tagCh_q  <= chCnt_q;
                    firstK_q <= (colCnt_q == 3'd0) && (chCnt_q == 5'd0);
                    lastK_q  <= atLastK;
                    last_q   <= atLastK && (conv_q == KER_LAST);
                    state_q  <= VLD;
                end
                VLD: begin
                    if (wif.w_ready) begin
                        valid_q  <= 1'b0;
                        tagCol_q <= 3'd0;
                        tagCh_q  <= 5'd0;
                        firstK_q <= 1'b0;
                        lastK_q  <= 1'b0;
                        last_q   <= 1'b0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q <= addr_q + 8'd1;
                            if (colCnt_q == 3'd4) begin
                                colCnt_q <= 3'd0;
                                if (chCnt_q == CH_LAST) begin
                                    chCnt_q <= 5'd0;
                                    conv_q  <= conv_q + 5'd1;
                                end else begin
                                    chCnt_q <= chCnt_q + 5'd1;
                                end
                            end else begin
                                colCnt_q <= colCnt_q + 3'd1;
                            end
                            state_q <= RD;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign wif.param_rd_addr = addr_q;
    assign wif.conv_cnt      = conv_q;
    assign wif.w_valid       = valid_q;
    assign wif.w_col         = tagCol_q;
    assign wif.w_ch          = tagCh_q;
    assign wif.w_first_k     = firstK_q;
    assign wif.w_last_k      = lastK_q;
    assign wif.w_last        = last_q;

endmodule

// File: tb/tb_param_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_param_rd_ctrl
//
// Purpose: exercises two controller instances, the default 16x3 layer (A)
// and a degenerate 1x1 layer (B), against a beat-index model: the model only
// tracks "which beat number is due and in which cycle", and derives address,
// kernel, channel, column and tags from the beat number arithmetically.
// ---------------------------------------------------------------------------
module tb_param_rd_ctrl;

    logic sclk = 1'b0;
    logic s_rst;
    logic startA, startB;
    logic busyA, doneA, busyB, doneB;
    logic wReady;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    param_rd_ctrl_if ifA ();
    param_rd_ctrl_if ifB ();

    assign ifA.w_ready = wReady;
    assign ifB.w_ready = wReady;

    param_rd_ctrl #(.KER_NUM(16), .CH_NUM(3)) dutA (
        .sclk  (sclk),
        .s_rst (s_rst),
        .start (startA),
        .busy  (busyA),
        .done  (doneA),
        .wif   (ifA)
    );

    param_rd_ctrl #(.KER_NUM(1), .CH_NUM(1)) dutB (
        .sclk  (sclk),
        .s_rst (s_rst),
        .start (startB),
        .busy  (busyB),
        .done  (doneB),
        .wif   (ifB)
    );

    // 10-unit clock period.
    always #5 sclk = ~sclk;

    // Model state, one slot per instance.
    int kerN [2] = '{16, 1};
    int chN  [2] = '{3, 1};
    bit active [2];
    int validAt [2];
    int beat [2];
    int doneAt [2];
    bit rstIdle [2];
    bit modelOn = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stA, input logic stB, input logic rdy);
        s_rst  = rst;
        startA = stA;
        startB = stB;
        wReady = rdy;
    endtask

    // Compare one instance against what the beat model says this cycle.
    task automatic checkOutput(input int d, input logic bsy, input logic dn, input logic vld,
                               input logic [7:0] addr, input logic [4:0] conv,
                               input logic [2:0] col, input logic [4:0] ch,
                               input logic fk, input logic lk, input logic la);
        int per;
        int n;
        int total;
        bit v;
        per   = 5 * chN[d];
        total = kerN[d] * per;
        n     = beat[d];
        v     = active[d] && (cyc >= validAt[d]);
        check($sformatf("dut%0d busy c%0d", d, cyc), int'(bsy), int'(active[d]));
        check($sformatf("dut%0d done c%0d", d, cyc), int'(dn), int'(cyc == doneAt[d]));
        check($sformatf("dut%0d valid c%0d", d, cyc), int'(vld), int'(v));
        if (v) begin
            check($sformatf("dut%0d addr c%0d", d, cyc), int'(addr), n);
            check($sformatf("dut%0d conv c%0d", d, cyc), int'(conv), n / per);
            check($sformatf("dut%0d col c%0d", d, cyc), int'(col), n % 5);
            check($sformatf("dut%0d ch c%0d", d, cyc), int'(ch), (n / 5) % chN[d]);
            check($sformatf("dut%0d firstk c%0d", d, cyc), int'(fk), int'((n % per) == 0));
            check($sformatf("dut%0d lastk c%0d", d, cyc), int'(lk), int'((n % per) == per - 1));
            check($sformatf("dut%0d last c%0d", d, cyc), int'(la), int'(n == total - 1));
        end else begin
            check($sformatf("dut%0d idle tags c%0d", d, cyc), int'({fk, lk, la, col, ch}), 0);
            if (rstIdle[d] && !active[d]) begin
                check($sformatf("dut%0d idle addr c%0d", d, cyc), int'({addr, conv}), 0);
            end
        end
    endtask

    // Model update on each rising edge using the inputs the DUT samples there.
    initial begin
        forever begin
            @(posedge sclk);
            for (int d = 0; d < 2; d++) begin
                logic st;
                st = (d == 0) ? startA : startB;
                if (s_rst) begin
                    active[d]  = 1'b0;
                    rstIdle[d] = 1'b1;
                    doneAt[d]  = -1;
                end else if (active[d]) begin
                    if (cyc >= validAt[d] && wReady) begin
                        if (beat[d] == kerN[d] * chN[d] * 5 - 1) begin
                            active[d] = 1'b0;
                            doneAt[d] = cyc + 1;
                        end else begin
                            beat[d]    = beat[d] + 1;
                            validAt[d] = cyc + 2;
                        end
                    end
                end else if (st && cyc != doneAt[d]) begin
                    active[d]  = 1'b1;
                    beat[d]    = 0;
                    validAt[d] = cyc + 2;
                    rstIdle[d] = 1'b0;
                end
            end
            if (s_rst) modelOn = 1'b1;
            cyc++;
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge sclk);
            if (modelOn) begin
                checkOutput(0, busyA, doneA, ifA.w_valid, ifA.param_rd_addr, ifA.conv_cnt,
                            ifA.w_col, ifA.w_ch, ifA.w_first_k, ifA.w_last_k, ifA.w_last);
                checkOutput(1, busyB, doneB, ifB.w_valid, ifB.param_rd_addr, ifB.conv_cnt,
                            ifB.w_col, ifB.w_ch, ifB.w_first_k, ifB.w_last_k, ifB.w_last);
            end
        end
    end

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        int s;
        int stallAt;
        int doneCyc;
        int doneCnt;
        bit finished;
        bit pulsed;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge sclk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset busyA", int'(busyA), 0);
        check("reset doneA", int'(doneA), 0);
        check("reset validA", int'(ifA.w_valid), 0);
        check("reset addrA", int'(ifA.param_rd_addr), 0);
        check("reset convA", int'(ifA.conv_cnt), 0);
        check("reset validB", int'(ifB.w_valid), 0);
        @(negedge sclk);

        // Full default layer plus the 1x1 layer, ready held high.
        s = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge sclk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check("run1 busy cycle1", int'(busyA), 1);
        finished = 1'b0;
        for (int k = 0; k < 700 && !finished; k++) begin
            if (cyc == s + 2) begin
                check("run1 beat0 valid", int'(ifA.w_valid), 1);
                check("run1 beat0 addr", int'(ifA.param_rd_addr), 0);
            end
            if (ifA.w_valid && ifA.param_rd_addr == 8'd14)
                check("run1 lastk at 14", int'({ifA.w_last_k, ifA.conv_cnt}), 32'h20);
            if (ifA.w_valid && ifA.param_rd_addr == 8'd15)
                check("run1 firstk at 15", int'({ifA.w_first_k, ifA.conv_cnt}), 32'h21);
            if (ifA.w_valid && ifA.param_rd_addr == 8'd239) begin
                check("run1 last at 239", int'({ifA.w_last, ifA.conv_cnt}), 32'h2f);
                check("run1 last cycle", cyc - s, 480);
            end
            if (ifB.w_valid && ifB.w_last) begin
                check("small last addr", int'(ifB.param_rd_addr), 4);
                check("small last cycle", cyc - s, 10);
            end
            if (doneB) check("small done cycle", cyc - s, 11);
            if (doneA) begin
                check("run1 done cycle", cyc - s, 481);
                finished = 1'b1;
            end
            @(negedge sclk);
        end
        if (!finished) check("run1 done timeout", 0, 1);

        // Back-pressure on beat 5, a stray start mid-stream and in DONE.
        repeat (2) @(negedge sclk);
        s = cyc;
        startA = 1'b1;
        @(negedge sclk);
        startA  = 1'b0;
        stallAt = -1;
        doneCyc = -1;
        doneCnt = 0;
        pulsed  = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 800 && !finished; k++) begin
            if (ifA.w_valid && ifA.param_rd_addr == 8'd5 && stallAt < 0) begin
                stallAt = cyc;
                wReady  = 1'b0;
            end else if (stallAt >= 0 && cyc > stallAt && cyc <= stallAt + 7) begin
                check("stall hold", int'({ifA.w_valid, ifA.param_rd_addr, ifA.w_col, ifA.w_ch}),
                      int'({1'b1, 8'd5, 3'd0, 5'd1}));
                if (cyc == stallAt + 7) wReady = 1'b1;
            end
            if (stallAt >= 0 && cyc == stallAt + 9)
                check("beat6 after stall", int'({ifA.w_valid, ifA.param_rd_addr}), int'({1'b1, 8'd6}));
            if (doneA) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc = cyc;
                    check("run2 done cycle", cyc - s, 488);
                end
            end
            if (ifA.w_valid && ifA.param_rd_addr == 8'd100 && !pulsed) begin
                startA = 1'b1;
                pulsed = 1'b1;
            end else begin
                startA = doneA;
            end
            if (doneCyc >= 0 && cyc == doneCyc + 10) finished = 1'b1;
            @(negedge sclk);
        end
        startA = 1'b0;
        if (!finished) check("run2 done timeout", 0, 1);
        check("run2 done count", doneCnt, 1);
        check("run2 no restart", int'(busyA), 0);

        // Reset mid-stream at beat 50, reset racing start, then a clean restart.
        startA = 1'b1;
        @(negedge sclk);
        startA = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 200 && !finished; k++) begin
            if (ifA.w_valid && ifA.param_rd_addr == 8'd50) finished = 1'b1;
            else @(negedge sclk);
        end
        if (!finished) check("beat50 timeout", 0, 1);
        s_rst = 1'b1;
        @(negedge sclk);
        s_rst = 1'b0;
        check("midrst outputs", int'({busyA, doneA, ifA.w_valid, ifA.param_rd_addr, ifA.conv_cnt}), 0);
        doneCnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge sclk);
            if (doneA) doneCnt++;
        end
        check("midrst no done", doneCnt, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge sclk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst beats start", int'(busyA), 0);
        s = cyc;
        startA = 1'b1;
        @(negedge sclk);
        startA = 1'b0;
        @(negedge sclk);
        check("restart beat0", int'({ifA.w_valid, ifA.w_first_k, ifA.param_rd_addr, ifA.conv_cnt}),
              int'({1'b1, 1'b1, 8'd0, 5'd0}));
        finished = 1'b0;
        for (int k = 0; k < 600 && !finished; k++) begin
            if (doneA) begin
                check("run3 done cycle", cyc - s, 481);
                finished = 1'b1;
            end
            @(negedge sclk);
        end
        if (!finished) check("run3 done timeout", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/param_rd_ctrl.md
PARAM_RD_CTRL -- requirements
Module: param_rd_ctrl

Interface
REQ-001 SHALL have parameter KER_NUM, default 16: kernels per layer, range 1..32.
REQ-002 SHALL have parameter CH_NUM, default 3: input channels per kernel; KER_NUM*CH_NUM*5 SHALL be <= 256.
REQ-003 SHALL have port sclk, input, 1: the block's one clock; all logic on the rising edge.
REQ-004 SHALL have port s_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to stream one layer's parameters.
REQ-006 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-007 SHALL have port done, output, 1: one-cycle pulse after the last beat is accepted.
REQ-008 SHALL have port param_rd_addr, output, 8: weight ROM address, shared by the five row ROMs.
REQ-009 SHALL have port conv_cnt, output, 5: kernel index; also the bias ROM address.
REQ-010 SHALL have port w_valid, output, 1: the weight/bias ROM outputs hold a valid beat this cycle.
REQ-011 SHALL have port w_ready, input, 1: consumer accepts the beat when w_valid && w_ready.
REQ-012 SHALL have port w_col, output, 3: kernel column of the current beat, 0..4.
REQ-013 SHALL have port w_ch, output, 5: input channel of the current beat.
REQ-014 SHALL have port w_first_k, output, 1: first beat of a kernel; the bias output is valid with it.
REQ-015 SHALL have port w_last_k, output, 1: last beat of a kernel (col 4, ch CH_NUM-1).
REQ-016 SHALL have port w_last, output, 1: last beat of the layer.

Function
REQ-017 SHALL treat the ROMs as synchronous, one-cycle read latency: an address driven in cycle c gives ROM data in cycle c+1.
REQ-018 SHALL implement the FSM IDLE -> RD -> VLD -> (RD | DONE) -> IDLE.
REQ-019 IDLE: start=1 SHALL clear all counters, set param_rd_addr=0 and conv_cnt=0, and move to RD.
REQ-020 RD: SHALL hold the address for one cycle, assert no outputs, and move to VLD.
REQ-021 VLD: SHALL assert w_valid and hold param_rd_addr, conv_cnt and all beat tags stable while w_ready=0.
REQ-022 VLD with w_ready=1 on a non-last beat: SHALL increment param_rd_addr by 1, advance the counters, and move to RD.
REQ-023 Counter order SHALL be col fastest (0..4), then ch (0..CH_NUM-1), then kernel (conv_cnt, 0..KER_NUM-1); each wraps to 0 when the next one increments.
REQ-024 param_rd_addr SHALL equal (conv_cnt*CH_NUM + w_ch)*5 + w_col at every beat.
REQ-025 VLD with w_ready=1 on the w_last beat SHALL move to DONE; DONE SHALL assert done for one cycle and then move to IDLE.
REQ-026 Throughput SHALL be one beat per 2 cycles with w_ready held high; total beats = KER_NUM*CH_NUM*5.
REQ-027 start while busy or in DONE SHALL be ignored, with no restart and no counter disturbance.
REQ-028 w_first_k, w_last_k, w_last, w_col and w_ch SHALL be meaningful only while w_valid=1, and 0 otherwise.
REQ-029 w_valid SHALL never be asserted in RD, IDLE or DONE.

Reset
REQ-030 s_rst=1 SHALL force IDLE and set busy, done, w_valid, param_rd_addr, conv_cnt and every counter and tag to 0 on the next edge.
REQ-031 Reset mid-stream SHALL abandon the layer with no done pulse; a later start SHALL restart from address 0.
REQ-032 s_rst SHALL take priority over start in the same cycle.

Verification
REQ-033 Defaults, start at cycle 0, w_ready=1 -> busy from cycle 1, beat n valid at cycle 2+2n with addr n, 240 beats, w_last at cycle 480, done at cycle 481.
REQ-034 w_ready=0 for 7 cycles on beat 5 -> w_valid, addr 5, w_col=0, w_ch=1 all stable for those 7 cycles; beat 6 follows 2 cycles after acceptance.
REQ-035 Kernel boundaries -> w_last_k at addr 14; w_first_k with conv_cnt=1 at addr 15; w_last with conv_cnt=15 and addr 239.
REQ-036 start pulsed at beat 100 -> ignored; the stream is unchanged and done asserts exactly once.
REQ-037 s_rst at beat 50, then start -> outputs are 0 the cycle after reset, no done pulse, and the new stream begins at addr 0 with conv_cnt=0.
REQ-038 KER_NUM=1, CH_NUM=1 -> 5 beats at addr 0..4; w_first_k on beat 0; w_last_k and w_last on beat 4; then done.
